// File: rtl/sr_latch_bank_if.sv
// sr_latch_bank_if: groups the control/data signals of sr_latch_bank.
//   master modport : drives ena, s, r, clr_err, err_sel; observes q, qn, changed,
//                    err_cnt, err_any.
//   slave modport  : the latch bank side (directions mirrored).
// Parameters CHANNELS and CNT_W must match the attached sr_latch_bank.
interface sr_latch_bank_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 4
);
    localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                ena;
    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] r;
    logic [CHANNELS-1:0] q;
    logic [CHANNELS-1:0] qn;
    logic [CHANNELS-1:0] changed;
    logic                clr_err;
    logic [SEL_W-1:0]    err_sel;
    logic [CNT_W-1:0]    err_cnt;
    logic                err_any;

    modport master (
        output ena, s, r, clr_err, err_sel,
        input  q, qn, changed, err_cnt, err_any
    );

    modport slave (
        input  ena, s, r, clr_err, err_sel,
        output q, qn, changed, err_cnt, err_any
    );
endinterface

// File: rtl/sr_latch_bank.sv
// sr_latch_bank: CHANNELS independent clocked SR cells with selectable S=R=1
// resolution, change pulses and per-channel saturating conflict counters.
// Ports:
//   clk     : clock, all state on rising edge
//   rst     : synchronous active-high reset
//   io_bus  : sr_latch_bank_if.slave (ena, s, r, clr_err, err_sel in;
//             q, qn, changed, err_cnt, err_any out)
// Parameters: CHANNELS (1..8), MODE (0 reset-dom, 1 set-dom, 2 hold, 3 toggle),
//             CNT_W (conflict counter width).
// Macro SR_LATCH_BANK_SYNC_EN: when defined, every s/r bit passes through a
// 2-flop synchroniser (s/r to q latency 3 cycles instead of 1).
module sr_latch_bank #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned MODE     = 0,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sr_latch_bank_if.slave        io_bus
);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CHANNELS-1:0] w_ss;
    logic [CHANNELS-1:0] w_sr;
    logic [CHANNELS-1:0] w_q_next;
    logic [CNT_W-1:0]    w_err_cnt;
    logic                w_err_any;

    logic [CHANNELS-1:0] r_q;
    logic [CHANNELS-1:0] r_qn;
    logic [CHANNELS-1:0] r_changed;
    logic [CNT_W-1:0]    r_cnt [CHANNELS];

`ifdef SR_LATCH_BANK_SYNC_EN
    logic [CHANNELS-1:0] r_s_meta;
    logic [CHANNELS-1:0] r_s_sync;
    logic [CHANNELS-1:0] r_r_meta;
    logic [CHANNELS-1:0] r_r_sync;

    // Keeps shifting while ena=0 so inputs are current when ena returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_meta <= '0;
            r_s_sync <= '0;
            r_r_meta <= '0;
            r_r_sync <= '0;
        end else begin
            r_s_meta <= io_bus.s;
            r_s_sync <= r_s_meta;
            r_r_meta <= io_bus.r;
            r_r_sync <= r_r_meta;
        end
    end

    assign w_ss = r_s_sync;
    assign w_sr = r_r_sync;
`else
    assign w_ss = io_bus.s;
    assign w_sr = io_bus.r;
`endif

    always_comb begin
        w_q_next = r_q;
        for (int i = 0; i < CHANNELS; i++) begin
            case ({w_ss[i], w_sr[i]})
                2'b10: w_q_next[i] = 1'b1;
                2'b01: w_q_next[i] = 1'b0;
                2'b11: begin
                    if (MODE == 0) begin
                        w_q_next[i] = 1'b0;
                    end else if (MODE == 1) begin
                        w_q_next[i] = 1'b1;
                    end else if (MODE == 3) begin
                        w_q_next[i] = ~r_q[i];
                    end
                    // MODE 2 holds
                end
                default: w_q_next[i] = r_q[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= '0;
            r_qn      <= '1;
            r_changed <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (io_bus.ena) begin
                r_q       <= w_q_next;
                r_qn      <= ~w_q_next;
                r_changed <= w_q_next ^ r_q;
            end else begin
                r_changed <= '0;
            end
            // Clear wins over a simultaneous conflict and ignores ena.
            for (int i = 0; i < CHANNELS; i++) begin
                if (io_bus.clr_err) begin
                    r_cnt[i] <= '0;
                end else if (io_bus.ena && w_ss[i] && w_sr[i] && (r_cnt[i] != CntMax)) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_err_cnt = '0;
        if (32'(io_bus.err_sel) < CHANNELS) begin
            w_err_cnt = r_cnt[io_bus.err_sel];
        end
        w_err_any = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_cnt[i] != '0) begin
                w_err_any = 1'b1;
            end
        end
    end

    assign io_bus.q       = r_q;
    assign io_bus.qn      = r_qn;
    assign io_bus.changed = r_changed;
    assign io_bus.err_cnt = w_err_cnt;
    assign io_bus.err_any = w_err_any;
endmodule

// File: doc/sr_latch_bank.md
Name: sr_latch_bank

Overview:
- Parametrised, clocked successor to the single cross-coupled NOR SR latch.
- Provides CHANNELS independent SR storage cells with selectable conflict resolution and per-channel conflict counting.
- Adds change-pulse outputs and an optional input synchroniser.
- Sits between raw set/reset sources (pads or analog comparators) and digital consumers that need glitch-free, registered Q/Qn.

Parameters:
- CHANNELS, 4, number of independent SR channels (1..8).
- MODE, 0, response to S=R=1: 0 reset-dominant, 1 set-dominant, 2 hold, 3 toggle.
- CNT_W, 4, width of each per-channel saturating conflict counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- ena  input  1  global enable; low freezes all state.
- s  input  CHANNELS  per-channel set request.
- r  input  CHANNELS  per-channel reset request.
- q  output  CHANNELS  registered latch state.
- qn  output  CHANNELS  registered complement of q.
- changed  output  CHANNELS  one-cycle pulse when the corresponding q bit changes.
- clr_err  input  1  synchronous clear of all conflict counters.
- err_sel  input  max(1,$clog2(CHANNELS))  selects which counter drives err_cnt.
- err_cnt  output  CNT_W  conflict count of the selected channel (combinational mux of registered counters).
- err_any  output  1  high when any conflict counter is nonzero.

Behaviour:
- One clock domain. Reset is synchronous and active-high; clock port is clk, reset port is rst.
- Reset values: q=0, qn=all ones, changed=0, all counters=0 (so err_cnt=0 and err_any=0), synchroniser flops=0.
- rst takes priority over every other input, including mid-operation and while ena=0.
- Sampled inputs:
  - ss = s and sr = r when the synchroniser is compiled out.
  - Otherwise ss and sr are the synchroniser outputs.
- Next-state rule per channel i, applied each cycle when ena=1:
  - ss=0, sr=0: hold.
  - ss=1, sr=0: q=1.
  - ss=0, sr=1: q=0.
  - ss=1, sr=1: MODE 0 gives q=0; MODE 1 gives q=1; MODE 2 holds; MODE 3 gives q=~q.
- qn is a separate register loaded with ~next_q; qn==~q holds on every cycle, including after reset.
- Latency: s/r to q/qn is 1 cycle without the synchroniser.
- changed[i]:
  - Registered; =1 for exactly one cycle, coincident with the cycle in which q[i] takes its new value.
  - =0 otherwise.
  - =0 on every cycle where ena=0 at the preceding edge.
- Conflict counter i:
  - Increments when ena=1 and ss[i]&sr[i]=1.
  - Saturates at 2^CNT_W-1 and never wraps.
- clr_err=1 zeroes all counters on the next edge.
  - clr_err beats a simultaneous conflict: counter ends at 0, not 1.
  - clr_err is honoured even when ena=0.
- err_sel >= CHANNELS: err_cnt=0.
- ena=0: q, qn and counters hold; changed=0. Synchroniser flops keep shifting, so inputs are current when ena returns.
- All channels operate simultaneously and independently; no cross-channel priority.

Optional Feature:
- Macro: SR_LATCH_BANK_SYNC_EN.
- Defined:
  - Each s and r bit passes through a 2-flop synchroniser before the next-state logic.
  - s/r to q latency becomes 3 cycles.
  - changed and counter timing shift identically.
  - Synchroniser flops reset to 0.
- Undefined:
  - No synchroniser flops are instantiated.
  - Latency is 1 cycle.
  - Inputs must be synchronous to clk.

Test Plan (CHANNELS=4, MODE=0, CNT_W=4, macro undefined unless stated):
- Reset: hold rst=1 for 2 cycles with s=4'hF -> q=4'h0, qn=4'hF, changed=0, err_any=0. Release rst -> q=4'hF, changed=4'hF for 1 cycle.
- Set/reset per channel: s=4'b0101 for 1 cycle -> next cycle q=4'b0101. Then r=4'b0001 -> q=4'b0100, changed=4'b0001 for 1 cycle. Idle 3 cycles -> q stays 4'b0100, changed=0.
- Conflict and MODE sweep: q[0]=1, s[0]=r[0]=1 for 1 cycle.
  - MODE 0 -> q[0]=0; MODE 1 -> q[0]=1; MODE 2 -> q[0]=1; MODE 3 -> q[0]=0.
  - In MODE 3, a second conflict cycle -> q[0]=1.
- Counter: s[2]=r[2]=1 for 20 cycles, err_sel=2 -> err_cnt saturates at 15, err_any=1.
  - clr_err=1 with conflict still active -> err_cnt=0.
  - Next conflict cycle -> err_cnt=1.
- Enable freeze: ena=0, s=4'hF, r=0 for 3 cycles from q=0 -> q=0, changed=0. Set ena=1 -> q=4'hF one cycle later.
- Macro defined: single-cycle s[1]=1 at cycle t -> q[1]=1 first visible at t+3, changed[1] pulses at t+3. rst asserted at t+1 -> q[1] stays 0 (synchroniser flops cleared).
